ysyx_24070016_lsu: RTL

YSYX_24070016_LSU -- requirements
Module: ysyx_24070016_lsu

---
 rtl/ysyx_24070016_pkg.sv | 27 ++
 rtl/ysyx_24070016_lsu_align.sv | 50 +++++
 rtl/ysyx_24070016_lsu.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ysyx_24070016_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, the
// controller state enum and the byte-lane offset helper.
package ysyx_24070016_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_WAIT = 2'b10,
        LSU_DONE = 2'b11
    } lsu_state_t;

    // Byte lane an access starts on; misaligned low bits are truncated.
    function automatic logic [1:0] lane_offset(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [1:0] off;
        case (size)
            SIZE_BYTE: off = addr_lo;
            SIZE_HALF: off = {addr_lo[1], 1'b0};
            default:   off = 2'b00;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/ysyx_24070016_lsu_align.sv
// Combinational lane steering: store byte mask, store data shift and
// load data extraction with sign/zero extension.
module ysyx_24070016_lsu_align
    import ysyx_24070016_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_store,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [1:0]  off;
    logic [4:0]  shamt;
    logic [31:0] rdata_sh;

    assign off      = lane_offset(size, addr_lo);
    assign shamt    = {off, 3'b000};
    assign wdata    = store_data << shamt;
    assign rdata_sh = rdata >> shamt;

    // Byte enables for stores; loads never enable any lane.
    always_comb begin
        wmask = 4'b0000;
        if (is_store) begin
            case (size)
                SIZE_BYTE: wmask = 4'b0001 << off;
                SIZE_HALF: wmask = 4'b0011 << off;
                default:   wmask = 4'b1111;
            endcase
        end
    end

    // Truncate the shifted read data to the access size and extend it.
    always_comb begin
        load_data = rdata_sh;
        case (size)
            SIZE_BYTE: load_data = is_unsigned ? {24'h0, rdata_sh[7:0]}
                                               : {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            SIZE_HALF: load_data = is_unsigned ? {16'h0, rdata_sh[15:0]}
                                               : {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            default:   load_data = rdata_sh;
        endcase
    end

endmodule

// File: rtl/ysyx_24070016_lsu.sv
// Load/store unit between EXU and WBU. One operation in flight at a time:
// IDLE accepts, REQ issues the memory request, WAIT collects load data,
// DONE presents the writeback result.
// Optional feature: define YSYX_24070016_LSU_MISALIGN_CHK_EN to flag
// misaligned half/word accesses instead of issuing them.
//
// Handshakes (in_*, out_*, dreq_*): a transfer happens on a rising edge
// where valid and ready are both 1; once valid is raised it stays high and
// its payload stays constant until that transfer.
module ysyx_24070016_lsu
    import ysyx_24070016_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] exu_result,
    input  logic [31:0] exu_src2,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] wb_data,
    output logic        dreq_valid,
    input  logic        dreq_ready,
    output logic [31:0] dreq_addr,
    output logic        dreq_we,
    output logic [31:0] dreq_wdata,
    output logic [3:0]  dreq_wmask,
    input  logic        drsp_valid,
    input  logic [31:0] drsp_rdata,
    output logic        lsu_misalign,
    output logic [1:0]  dbg_state
);

    lsu_state_t  state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] src2_q;
    logic        wen_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] load_data;
    logic        accept;
    logic        mem_op;

    assign accept    = (state_q == LSU_IDLE) && in_valid;
    assign mem_op    = mem_ren | mem_wen;
    assign dbg_state = state_q;

    assign dreq_addr = {addr_q[31:2], 2'b00};
    assign dreq_we   = wen_q;

`ifdef YSYX_24070016_LSU_MISALIGN_CHK_EN
    logic mis_in;
    logic misalign_q;

    assign mis_in = mem_op &&
                    (((mem_size == SIZE_HALF) && exu_result[0]) ||
                     (mem_size[1] && (exu_result[1:0] != 2'b00)));
    assign lsu_misalign = misalign_q;

    // Misalign flag is captured with the operation and held through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else if (accept) begin
            misalign_q <= mis_in;
        end
    end
`else
    assign lsu_misalign = 1'b0;
`endif

    ysyx_24070016_lsu_align u_align (
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .is_store    (wen_q),
        .is_unsigned (uns_q),
        .store_data  (src2_q),
        .rdata       (drsp_rdata),
        .wmask       (dreq_wmask),
        .wdata       (dreq_wdata),
        .load_data   (load_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LSU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        dreq_valid = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (!mem_op) begin
                        state_d = LSU_DONE;
                    end
`ifdef YSYX_24070016_LSU_MISALIGN_CHK_EN
                    else if (mis_in) begin
                        state_d = LSU_DONE;
                    end
`endif
                    else begin
                        state_d = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                dreq_valid = 1'b1;
                if (dreq_ready) begin
                    state_d = wen_q ? LSU_DONE : LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                if (drsp_valid) begin
                    state_d = LSU_DONE;
                end
            end
            LSU_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    // Operation capture and writeback data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= 32'h0;
            src2_q  <= 32'h0;
            wen_q   <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wb_data <= 32'h0;
        end else if (accept) begin
            addr_q  <= exu_result;
            src2_q  <= exu_src2;
            wen_q   <= mem_wen;
            size_q  <= mem_size;
            uns_q   <= mem_unsigned;
            wb_data <= mem_op ? 32'h0 : exu_result;
        end else if ((state_q == LSU_REQ) && dreq_ready && wen_q) begin
            wb_data <= 32'h0;
        end else if ((state_q == LSU_WAIT) && drsp_valid) begin
            wb_data <= load_data;
        end
    end

endmodule
